// File: rtl/tl_xbar_pkg.sv
// Shared crossbar definitions: the default TileLink beat width and a width helper
// that is used to size the pointer and count registers.
package tl_xbar_pkg;

    localparam int TL_BEAT_W = 8;

    // Number of bits needed to hold the values 0..n-1. The result is always at least 1.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tl_channel_queue_if.sv
// Handshake bundle for one TileLink channel queue: an upstream beat in, a head beat out,
// and the queue occupancy.
interface tl_channel_queue_if #(
    parameter int DATA_W = tl_xbar_pkg::TL_BEAT_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = tl_xbar_pkg::clog2_w(DEPTH + 1);

    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/tl_queue_ram.sv
// DEPTH x DATA_W queue storage with one synchronous write port and one asynchronous read port.
// The storage array is not reset.
module tl_queue_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tl_channel_queue.sv
// Elastic in-order FIFO for one TileLink channel, placed downstream of the crossbar arbiter.
// Define TL_QUEUE_FLOW_EN to let a beat fall through the queue when the queue is empty.
module tl_channel_queue
    import tl_xbar_pkg::*;
#(
    parameter int DATA_W = TL_BEAT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    tl_channel_queue_if.slave q
);
    localparam int PTR_W = clog2_w(DEPTH);
    localparam int CNT_W = clog2_w(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              has_data;
    logic              can_accept;
    logic              bypass;
    logic              push;
    logic              pop;

    assign has_data   = (count_q != '0);
    assign can_accept = !rst && (count_q != FULL);

`ifdef TL_QUEUE_FLOW_EN
    assign bypass = !rst && !has_data && q.valid_i;
`else
    assign bypass = 1'b0;
`endif

    // When a bypassed beat is taken downstream in the same cycle, it never touches storage.
    assign push = q.valid_i && can_accept && !(bypass && q.ready_i);
    assign pop  = !rst && has_data && q.ready_i;

    always_comb begin
        q.ready_o = can_accept;
        q.valid_o = !rst && (has_data || bypass);
        q.count_o = rst ? '0 : count_q;
        q.data_o  = '0;
        if (!rst && has_data) begin
            q.data_o = ram_rdata;
        end else if (bypass) begin
            q.data_o = q.data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    tl_queue_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (q.data_i),
        .raddr  (rd_ptr_q),
        .rdata  (ram_rdata)
    );
endmodule

// File: tb/tb_tl_channel_queue.sv
// Directed bench for tl_channel_queue (base build): reset, fill and overflow, drain,
// push and pop together, streaming with pointer wrap, and reset while the queue holds beats.
module tb_tl_channel_queue;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tl_channel_queue_if #(.DATA_W(8), .DEPTH(4)) bus ();

    tl_channel_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lets combinational outputs settle, then compares all four observable outputs.
    task automatic checkOutput(input string tag, input logic r, input logic v,
                               input logic [7:0] d, input logic [2:0] c);
        #1;
        check({tag, ".ready_o"}, 32'(bus.ready_o), 32'(r));
        check({tag, ".valid_o"}, 32'(bus.valid_o), 32'(v));
        check({tag, ".data_o"},  32'(bus.data_o),  32'(d));
        check({tag, ".count_o"}, 32'(bus.count_o), 32'(c));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Test 1: hold reset for three cycles while upstream offers a beat.
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst%0d", i), 1'b0, 1'b0, 8'h00, 3'd0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rst_release", 1'b1, 1'b0, 8'h00, 3'd0);

        // Test 2: fill with A0..A3, then offer A4 while the queue is full.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
            checkOutput($sformatf("fill%0d", i), 1'b1, (i > 0), (i > 0) ? 8'hA0 : 8'h00, 3'(i));
            tick();
        end
        applyStimulus(1'b1, 8'hA4, 1'b0);
        checkOutput("full_offer", 1'b0, 1'b1, 8'hA0, 3'd4);
        tick();
        checkOutput("full_hold", 1'b0, 1'b1, 8'hA0, 3'd4);

        // Test 3: drain the full queue.
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d", i), (i != 0), 1'b1, 8'hA0 + 8'(i), 3'(4 - i));
            tick();
        end
        checkOutput("drain_empty", 1'b1, 1'b0, 8'h00, 3'd0);

        // Test 4: with B0 and B1 stored, push B2 while B0 is popped.
        applyStimulus(1'b1, 8'hB0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hB1, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hB2, 1'b1);
        checkOutput("pp_b0", 1'b1, 1'b1, 8'hB0, 3'd2);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("pp_b1", 1'b1, 1'b1, 8'hB1, 3'd2);
        tick();
        checkOutput("pp_b2", 1'b1, 1'b1, 8'hB2, 3'd1);
        tick();
        checkOutput("pp_empty", 1'b1, 1'b0, 8'h00, 3'd0);

        // Test 5: stream C0..C9 at full rate. Each beat appears one cycle after it is pushed.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1);
            checkOutput($sformatf("stream%0d", i), 1'b1, (i > 0),
                        (i > 0) ? 8'hC0 + 8'(i - 1) : 8'h00, (i > 0) ? 3'd1 : 3'd0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("stream_last", 1'b1, 1'b1, 8'hC9, 3'd1);
        tick();
        checkOutput("stream_empty", 1'b1, 1'b0, 8'h00, 3'd0);

        // Test 6: reset while D0..D2 are held. Only E0 may be delivered afterwards.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pre_reset", 1'b1, 1'b1, 8'hD0, 3'd3);
        rst = 1'b1;
        checkOutput("mid_reset", 1'b0, 1'b0, 8'h00, 3'd0);
        tick();
        rst = 1'b0;
        checkOutput("post_reset", 1'b1, 1'b0, 8'h00, 3'd0);
        applyStimulus(1'b1, 8'hE0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("e0_head", 1'b1, 1'b1, 8'hE0, 3'd1);
        tick();
        checkOutput("e0_gone", 1'b1, 1'b0, 8'h00, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
